// File: rtl/loader_pkg.sv
// Shared opcodes, FSM state encoding and default response bytes for the stream loader.
package loader_pkg;

  localparam logic [1:0] OP_PING   = 2'b00;
  localparam logic [1:0] OP_IMEM   = 2'b01;
  localparam logic [1:0] OP_BMEM   = 2'b10;
  localparam logic [1:0] OP_UPDATE = 2'b11;

  localparam logic [7:0] ACK_DEFAULT = 8'h06;
  localparam logic [7:0] NAK_DEFAULT = 8'h15;

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StData,
    StMask,
    StCheck,
    StCommit,
    StResp
  } state_e;

endpackage

// File: rtl/stream_loader_if.sv
// Byte-stream link between the UART controller (master) and the loader (slave).
interface stream_loader_if;

  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (
    output rx_data, rx_valid, tx_ready,
    input  rx_ready, tx_data, tx_valid
  );

  modport slave (
    input  rx_data, rx_valid, tx_ready,
    output rx_ready, tx_data, tx_valid
  );

endinterface

// File: rtl/loader_word_assembler.sv
// Little-endian byte-to-word shifter; `last` flags the byte that completes a word and `word`
// already includes that byte.
module loader_word_assembler #(
  parameter int unsigned BITWIDTH = 32
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                in_valid,
  input  logic [7:0]          in_byte,
  output logic [BITWIDTH-1:0] word,
  output logic                last
);

  localparam int unsigned Bytes = BITWIDTH / 8;
  localparam int unsigned CntW  = (Bytes > 1) ? $clog2(Bytes) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(Bytes - 1);

  logic [CntW-1:0] cnt_q;

  assign last = in_valid && (cnt_q == LastCnt);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (in_valid) begin
      cnt_q <= last ? '0 : cnt_q + 1'b1;
    end
  end

  generate
    if (BITWIDTH > 8) begin : g_shift
      logic [BITWIDTH-9:0] rest_q;
      // Newest byte enters at the top so the first byte ends up in the LSBs.
      assign word = {in_byte, rest_q};
      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          rest_q <= '0;
        end else if (in_valid) begin
          rest_q <= word[BITWIDTH-1:8];
        end
      end
    end else begin : g_single
      assign word = in_byte;
    end
  endgenerate

endmodule

// File: rtl/stream_loader.sv
// Framed byte-stream command loader for IMEM/BMEM writes and thread masks, with ACK/NAK replies.
// Optional trailing XOR checksum byte per command when LOADER_CHECKSUM_EN is defined.
module stream_loader
  import loader_pkg::*;
#(
  parameter int unsigned BITWIDTH    = 32,
  parameter int unsigned NUM_THREADS = 2,
  parameter int unsigned BLOCK_WORDS = 16,
  parameter logic [7:0]  ACK_BYTE    = ACK_DEFAULT,
  parameter logic [7:0]  NAK_BYTE    = NAK_DEFAULT
) (
  input  logic                            clock,
  input  logic                            reset,
  stream_loader_if.slave                  uart,
  output logic [BITWIDTH-1:0]             wr_addr,
  output logic [BITWIDTH-1:0]             imem_wr_data,
  output logic [NUM_THREADS-1:0]          imem_wr_valid,
  output logic [BLOCK_WORDS*BITWIDTH-1:0] bmem_wr_data,
  output logic                            bmem_wr_valid,
  output logic [NUM_THREADS-1:0]          thread_start,
  output logic [NUM_THREADS-1:0]          thread_enabled
);

  localparam int unsigned IdxW = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1;
  localparam logic [IdxW-1:0] LastWord = IdxW'(BLOCK_WORDS - 1);

  state_e                            state_q;
  logic [1:0]                        op_q;
  logic [5:0]                        tsel_q;
  logic [IdxW-1:0]                   word_idx_q;
  logic                              mask_cnt_q;
  logic [NUM_THREADS-1:0]            start_q;
  logic                              ack_q;
  logic                              rx_ready_q;
  logic [7:0]                        tx_data_q;
  logic                              tx_valid_q;
  logic [BITWIDTH-1:0]               wr_addr_q;
  logic [BITWIDTH-1:0]               imem_data_q;
  logic [NUM_THREADS-1:0]            imem_valid_q;
  logic [BLOCK_WORDS*BITWIDTH-1:0]   bmem_data_q;
  logic                              bmem_valid_q;
  logic [NUM_THREADS-1:0]            start_pulse_q;
  logic [NUM_THREADS-1:0]            enabled_q;

  logic                   hs;
  logic                   asm_valid;
  logic                   asm_last;
  logic [BITWIDTH-1:0]    asm_word;
  logic                   data_last;
  logic                   mask_last;
  logic                   fire;
  logic                   good;
  logic [NUM_THREADS-1:0] enable_src;
  logic [NUM_THREADS-1:0] imem_sel;

  assign hs        = uart.rx_valid && rx_ready_q;
  assign asm_valid = hs && ((state_q == StAddr) || (state_q == StData));
  assign data_last = asm_last && (state_q == StData) &&
                     ((op_q == OP_IMEM) || (word_idx_q == LastWord));
  assign mask_last = hs && (state_q == StMask) && mask_cnt_q;

  // Empty when tsel is out of range or the target thread is running.
  always_comb begin
    imem_sel = '0;
    for (int i = 0; i < int'(NUM_THREADS); i++) begin
      imem_sel[i] = (tsel_q == 6'(i)) && !enabled_q[i];
    end
  end

`ifdef LOADER_CHECKSUM_EN
  logic [7:0]             csum_q;
  logic [NUM_THREADS-1:0] enable_q;
  assign fire       = hs && (state_q == StCheck);
  assign good       = (uart.rx_data == csum_q);
  assign enable_src = enable_q;
`else
  assign fire       = data_last || mask_last;
  assign good       = 1'b1;
  assign enable_src = uart.rx_data[NUM_THREADS-1:0];
`endif

  loader_word_assembler #(
    .BITWIDTH (BITWIDTH)
  ) u_asm (
    .clock    (clock),
    .reset    (reset),
    .in_valid (asm_valid),
    .in_byte  (uart.rx_data),
    .word     (asm_word),
    .last     (asm_last)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= StIdle;
      op_q          <= OP_PING;
      tsel_q        <= '0;
      word_idx_q    <= '0;
      mask_cnt_q    <= 1'b0;
      start_q       <= '0;
      ack_q         <= 1'b0;
      rx_ready_q    <= 1'b0;
      tx_data_q     <= '0;
      tx_valid_q    <= 1'b0;
      wr_addr_q     <= '0;
      imem_data_q   <= '0;
      imem_valid_q  <= '0;
      bmem_data_q   <= '0;
      bmem_valid_q  <= 1'b0;
      start_pulse_q <= '0;
      enabled_q     <= '0;
`ifdef LOADER_CHECKSUM_EN
      csum_q        <= '0;
      enable_q      <= '0;
`endif
    end else begin
      imem_valid_q  <= '0;
      bmem_valid_q  <= 1'b0;
      start_pulse_q <= '0;
`ifdef LOADER_CHECKSUM_EN
      if (hs && (state_q != StIdle)) csum_q <= csum_q ^ uart.rx_data;
`endif
      case (state_q)
        StIdle: begin
          rx_ready_q <= 1'b1;
          if (hs) begin
            op_q       <= uart.rx_data[7:6];
            tsel_q     <= uart.rx_data[5:0];
            word_idx_q <= '0;
            mask_cnt_q <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            csum_q     <= uart.rx_data;
`endif
            case (uart.rx_data[7:6])
              OP_IMEM, OP_BMEM: state_q <= StAddr;
              OP_UPDATE:        state_q <= StMask;
              default: begin
`ifdef LOADER_CHECKSUM_EN
                state_q    <= StCheck;
`else
                state_q    <= StResp;
                rx_ready_q <= 1'b0;
                tx_data_q  <= ACK_BYTE;
                tx_valid_q <= 1'b1;
`endif
              end
            endcase
          end
        end
        StAddr: begin
          if (asm_last) begin
            wr_addr_q <= asm_word;
            state_q   <= StData;
          end
        end
        StData: begin
          if (asm_last) begin
            if (op_q == OP_IMEM) begin
              imem_data_q <= asm_word;
            end else begin
              bmem_data_q[word_idx_q*BITWIDTH +: BITWIDTH] <= asm_word;
              word_idx_q <= word_idx_q + 1'b1;
            end
`ifdef LOADER_CHECKSUM_EN
            if (data_last) state_q <= StCheck;
`endif
          end
        end
        StMask: begin
          if (hs) begin
            mask_cnt_q <= 1'b1;
            if (!mask_cnt_q) begin
              start_q <= uart.rx_data[NUM_THREADS-1:0];
            end else begin
`ifdef LOADER_CHECKSUM_EN
              enable_q <= uart.rx_data[NUM_THREADS-1:0];
              state_q  <= StCheck;
`endif
            end
          end
        end
        StCommit: begin
          tx_data_q  <= ack_q ? ACK_BYTE : NAK_BYTE;
          tx_valid_q <= 1'b1;
          state_q    <= StResp;
        end
        StResp: begin
          if (uart.tx_ready) begin
            tx_valid_q <= 1'b0;
            rx_ready_q <= 1'b1;
            state_q    <= StIdle;
          end
        end
        default: ;
      endcase

      // Strobes are registered on the final byte so they are high during the COMMIT cycle.
      if (fire) begin
        state_q    <= StCommit;
        rx_ready_q <= 1'b0;
        ack_q      <= good;
        case (op_q)
          OP_IMEM: begin
            ack_q <= good && (|imem_sel);
            if (good) imem_valid_q <= imem_sel;
          end
          OP_BMEM: bmem_valid_q <= good;
          OP_UPDATE: begin
            if (good) begin
              start_pulse_q <= start_q;
              enabled_q     <= enable_src;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign uart.rx_ready  = rx_ready_q;
  assign uart.tx_data   = tx_data_q;
  assign uart.tx_valid  = tx_valid_q;
  assign wr_addr        = wr_addr_q;
  assign imem_wr_data   = imem_data_q;
  assign imem_wr_valid  = imem_valid_q;
  assign bmem_wr_data   = bmem_data_q;
  assign bmem_wr_valid  = bmem_valid_q;
  assign thread_start   = start_pulse_q;
  assign thread_enabled = enabled_q;

endmodule

// File: tb/tb_stream_loader.sv
// Bench for stream_loader: directed plan steps plus randomized commands against a command-level
// model; honours LOADER_CHECKSUM_EN by appending the XOR byte.
module tb_stream_loader;

  localparam int BW  = 32;
  localparam int NT  = 2;
  localparam int BLK = 4;
  localparam int B   = BW / 8;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  stream_loader_if bus ();

  logic [BW-1:0]     wr_addr;
  logic [BW-1:0]     imem_wr_data;
  logic [NT-1:0]     imem_wr_valid;
  logic [BLK*BW-1:0] bmem_wr_data;
  logic              bmem_wr_valid;
  logic [NT-1:0]     thread_start;
  logic [NT-1:0]     thread_enabled;

  stream_loader #(
    .BITWIDTH    (BW),
    .NUM_THREADS (NT),
    .BLOCK_WORDS (BLK)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .uart           (bus),
    .wr_addr        (wr_addr),
    .imem_wr_data   (imem_wr_data),
    .imem_wr_valid  (imem_wr_valid),
    .bmem_wr_data   (bmem_wr_data),
    .bmem_wr_valid  (bmem_wr_valid),
    .thread_start   (thread_start),
    .thread_enabled (thread_enabled)
  );

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;
  int hs_cyc     = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {int c; logic [NT-1:0] sel; logic [BW-1:0] addr; logic [BW-1:0] data;} imem_ev_t;
  typedef struct {int c; logic [BW-1:0] addr; logic [BLK*BW-1:0] data;} bmem_ev_t;
  typedef struct {int c; logic [NT-1:0] mask;} start_ev_t;

  imem_ev_t  imem_q[$];
  bmem_ev_t  bmem_q[$];
  start_ev_t start_q[$];
  imem_ev_t  ie;
  bmem_ev_t  be;
  start_ev_t se;

  // Strobe monitor: one queue entry per cycle a strobe is high.
  always @(negedge clock) begin
    if (imem_wr_valid != '0) begin
      ie.c = cyc; ie.sel = imem_wr_valid; ie.addr = wr_addr; ie.data = imem_wr_data;
      imem_q.push_back(ie);
    end
    if (bmem_wr_valid) begin
      be.c = cyc; be.addr = wr_addr; be.data = bmem_wr_data;
      bmem_q.push_back(be);
    end
    if (thread_start != '0) begin
      se.c = cyc; se.mask = thread_start;
      start_q.push_back(se);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [BLK*BW-1:0] obs, input logic [BLK*BW-1:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Command-level reference state.
  logic [NT-1:0] m_en = '0;
  logic [7:0]    pl[$];
  logic [7:0]    csum;
  bit            csum_flip = 1'b0;

  // Called at a negedge; returns at the negedge after the byte was taken.
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    if ($urandom_range(0, 3) == 0) @(negedge clock);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    while (!bus.rx_ready && n < 200) begin
      @(negedge clock);
      n++;
    end
    chk("rx_accept", bus.rx_ready, 1);
    hs_cyc = cyc + 1;
    csum = csum ^ b;
    @(negedge clock);
    bus.rx_valid = 1'b0;
  endtask

  task automatic send_cmd(input logic [7:0] hdr);
    csum = 8'h00;
    send_byte(hdr);
    foreach (pl[i]) send_byte(pl[i]);
`ifdef LOADER_CHECKSUM_EN
    send_byte(csum ^ (csum_flip ? 8'hFF : 8'h00));
`endif
  endtask

  task automatic get_resp(input int stall, output logic [7:0] r);
    int n = 0;
    bit stable = 1'b1;
    bus.tx_ready = 1'b0;
    while (!bus.tx_valid && n < 200) begin
      @(negedge clock);
      n++;
    end
    chk("tx_valid_rise", bus.tx_valid, 1);
    r = bus.tx_data;
    for (int i = 0; i < stall; i++) begin
      @(negedge clock);
      if (bus.tx_valid !== 1'b1 || bus.tx_data !== r || bus.rx_ready !== 1'b0) stable = 1'b0;
    end
    chk("resp_hold", stable, 1);
    bus.tx_ready = 1'b1;
    @(negedge clock);
    bus.tx_ready = 1'b0;
    chk("tx_valid_one_cycle", bus.tx_valid, 0);
    chk("rx_ready_back", bus.rx_ready, 1);
  endtask

  // Send one command from header + pl and check everything the model predicts.
  task automatic do_cmd(input logic [7:0] hdr, input int stall);
    logic [1:0]        op;
    int                t;
    bit                good;
    bit                ok;
    logic [7:0]        r;
    logic [BW-1:0]     addr;
    logic [BW-1:0]     data;
    logic [BLK*BW-1:0] blk;
    logic [NT-1:0]     st;
    int n_imem = 0, n_bmem = 0, n_start = 0;
    logic [7:0]        exp_r;
    imem_q.delete(); bmem_q.delete(); start_q.delete();
    op   = hdr[7:6];
    t    = int'(hdr[5:0]);
`ifdef LOADER_CHECKSUM_EN
    good = !csum_flip;
`else
    good = 1'b1;
`endif
    addr = '0; data = '0; blk = '0; st = '0;
    if (op == 2'b01 || op == 2'b10) begin
      for (int i = 0; i < B; i++) addr[i*8 +: 8] = pl[i];
    end
    ok = good;
    case (op)
      2'b01: begin
        for (int i = 0; i < B; i++) data[i*8 +: 8] = pl[B + i];
        ok = good && (t < NT) && !m_en[t];
        n_imem = ok ? 1 : 0;
      end
      2'b10: begin
        // Byte k lands in word k/B, lane k%B: bit offset 8*k of the flattened block.
        for (int k = 0; k < B * BLK; k++) blk[k*8 +: 8] = pl[B + k];
        n_bmem = good ? 1 : 0;
      end
      2'b11: begin
        if (good) begin
          st      = pl[0][NT-1:0];
          m_en    = pl[1][NT-1:0];
          n_start = (st != '0) ? 1 : 0;
        end
      end
      default: ;
    endcase
    send_cmd(hdr);
    get_resp(stall, r);
    exp_r = ok ? 8'h06 : 8'h15;
    chk("resp_byte", r, exp_r);
    chk("imem_strobes", imem_q.size(), n_imem);
    chk("bmem_strobes", bmem_q.size(), n_bmem);
    chk("start_strobes", start_q.size(), n_start);
    if (imem_q.size() == 1 && n_imem == 1) begin
      chk("imem_sel", imem_q[0].sel, NT'(1) << t);
      chk("imem_addr", imem_q[0].addr, addr);
      chk("imem_data", imem_q[0].data, data);
      chk("imem_latency", imem_q[0].c, hs_cyc);
    end
    if (bmem_q.size() == 1 && n_bmem == 1) begin
      chk("bmem_addr", bmem_q[0].addr, addr);
      chk("bmem_data", bmem_q[0].data, blk);
      chk("bmem_latency", bmem_q[0].c, hs_cyc);
    end
    if (start_q.size() == 1 && n_start == 1) begin
      chk("start_mask", start_q[0].mask, st);
      chk("start_latency", start_q[0].c, hs_cyc);
    end
    chk("thread_enabled", thread_enabled, m_en);
  endtask

  task automatic push_word(input logic [BW-1:0] w);
    for (int i = 0; i < B; i++) pl.push_back(w[i*8 +: 8]);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_rx_ready"}, bus.rx_ready, 0);
    chk({tag, "_tx_valid"}, bus.tx_valid, 0);
    chk({tag, "_tx_data"}, bus.tx_data, 0);
    chk({tag, "_strobes"}, {imem_wr_valid, bmem_wr_valid, thread_start}, 0);
    chk({tag, "_enabled"}, thread_enabled, 0);
  endtask

  initial begin
    logic [7:0] hdr;
    logic [1:0] op;
    bus.rx_data  = '0;
    bus.rx_valid = 1'b0;
    bus.tx_ready = 1'b0;

    repeat (3) @(negedge clock);
    check_reset_outputs("reset");
    reset = 1'b1;
    #1 chk("rx_ready_before_clock", bus.rx_ready, 0);
    @(negedge clock);
    chk("rx_ready_after_reset", bus.rx_ready, 1);

    // PING
    pl.delete();
    do_cmd(8'h00, 0);

    // IMEM write to thread 1
    pl.delete();
    pl = '{8'h10, 8'h00, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    do_cmd(8'h41, 0);
    chk("imem_wr_addr_hold", wr_addr, 32'h10);
    chk("imem_wr_data_hold", imem_wr_data, 32'hDEADBEEF);

    // UPDATE start=01 enable=03, then IMEM to enabled thread 0 gets NAK
    pl.delete();
    pl = '{8'h01, 8'h03};
    do_cmd(8'hC0, 0);
    pl.delete();
    push_word(32'h44); push_word(32'h12345678);
    do_cmd(8'h40, 0);

    // BMEM block with a 10-cycle response stall
    pl.delete();
    push_word(32'h20);
    for (int w = 1; w <= BLK; w++) push_word(BW'(w));
    do_cmd(8'h80, 10);
    chk("bmem_block_hold", bmem_wr_data, {32'd4, 32'd3, 32'd2, 32'd1});

    // Clear enables, then out-of-range thread select
    pl.delete();
    pl = '{8'h00, 8'h00};
    do_cmd(8'hC0, 0);
    pl.delete();
    push_word(32'h8); push_word(32'hCAFE);
    do_cmd(8'h47, 0);

    // Randomized commands
    for (int n = 0; n < 40; n++) begin
      op = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) hdr = {op, 6'($urandom_range(0, 63))};
      else hdr = {op, 6'($urandom_range(0, NT - 1))};
`ifdef LOADER_CHECKSUM_EN
      csum_flip = ($urandom_range(0, 5) == 0);
`endif
      pl.delete();
      case (op)
        2'b01: begin push_word(BW'($urandom)); push_word(BW'($urandom)); end
        2'b10: for (int w = 0; w <= BLK; w++) push_word(BW'($urandom));
        2'b11: begin
          pl.push_back(8'($urandom));
          pl.push_back(($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom));
        end
        default: ;
      endcase
      do_cmd(hdr, $urandom_range(0, 3));
    end
    csum_flip = 1'b0;

`ifdef LOADER_CHECKSUM_EN
    pl.delete();
    csum_flip = 1'b1;
    do_cmd(8'h00, 0);
    csum_flip = 1'b0;
    do_cmd(8'h00, 0);
`endif

    // Set some enables, then abort a BMEM command with reset
    pl.delete();
    pl = '{8'h00, 8'h02};
    do_cmd(8'hC0, 0);
    bmem_q.delete();
    csum = 8'h00;
    send_byte(8'h80);
    for (int i = 0; i < B + 3; i++) send_byte(8'($urandom));
    reset = 1'b0;
    m_en  = '0;
    #1 check_reset_outputs("abort");
    repeat (3) @(negedge clock);
    chk("abort_no_bmem", bmem_q.size(), 0);
    chk("abort_no_resp", bus.tx_valid, 0);
    reset = 1'b1;
    @(negedge clock);
    pl.delete();
    do_cmd(8'h00, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/stream_loader.md
Name: stream_loader

Overview:
- Byte-stream command loader that sits between the UART controller's receive/transmit byte ports and the core's memories and threads.
- Parses framed commands to write IMEM words into a selected thread's IMEM, write full BMEM blocks, and update thread start/enable masks.
- Returns an ACK/NAK byte per command.
- Generalises the core-internal loader:
  - any number of threads up to 8, with an explicit thread select instead of "first disabled thread";
  - any BITWIDTH that is a multiple of 8;
  - any block size;
  - a response channel with backpressure.

Parameters:
- BITWIDTH, 32, data/address word width in bits; must be a multiple of 8 and at least 8.
- NUM_THREADS, 2, number of threads/IMEMs; range 1..8.
- BLOCK_WORDS, 16, words per BMEM block write (MESHUNITS²·TILEUNITS² at instantiation).
- ACK_BYTE, 8'h06, response byte for a successful command.
- NAK_BYTE, 8'h15, response byte for a rejected command.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous active-low reset
- rx_data  in  8  received byte
- rx_valid  in  1  rx_data valid this cycle
- rx_ready  out  1  loader accepts a byte; a transfer happens when rx_valid && rx_ready
- tx_data  out  8  response byte
- tx_valid  out  1  response pending
- tx_ready  in  1  UART takes the response; a transfer happens when tx_valid && tx_ready
- wr_addr  out  BITWIDTH  IMEM/BMEM write address (shared)
- imem_wr_data  out  BITWIDTH  IMEM write word
- imem_wr_valid  out  NUM_THREADS  one-hot IMEM write strobe
- bmem_wr_data  out  BLOCK_WORDS*BITWIDTH  flattened block; word i at [i*BITWIDTH +: BITWIDTH]
- bmem_wr_valid  out  1  BMEM block write strobe
- thread_start  out  NUM_THREADS  one-cycle start pulses
- thread_enabled  out  NUM_THREADS  registered enable mask

Behaviour:
- Reset (reset==0, asynchronous) drives:
  - state IDLE, all counters 0;
  - all strobes, thread_start and thread_enabled 0;
  - tx_valid 0, tx_data 0, rx_ready 0.
  rx_ready rises on the first clock after reset deasserts.
- Header byte: [7:6] opcode, [5:0] thread select tsel.
  - 00 PING: no payload.
  - 01 IMEM: payload is addr then one data word.
  - 10 BMEM: payload is addr then BLOCK_WORDS words.
  - 11 UPDATE: payload is start mask byte then enable mask byte.
- All multi-byte fields are little-endian; B = BITWIDTH/8 bytes per word.
- States:
  - IDLE -> ADDR (opcodes 01/10), MASK (opcode 11), or RESP (opcode 00).
  - ADDR: consume B bytes -> DATA.
  - DATA: consume B (IMEM) or B*BLOCK_WORDS (BMEM) bytes -> CHECK if the optional feature is compiled in, else COMMIT.
  - MASK: consume 2 bytes -> CHECK or COMMIT.
  - COMMIT: one cycle, performs the action -> RESP.
  - RESP: tx_valid=1 until the tx handshake -> IDLE.
- rx_ready is 1 only in IDLE/ADDR/DATA/MASK/CHECK; it is 0 in COMMIT and RESP. Bytes are never dropped.
- Byte counter width is clog2(B*BLOCK_WORDS+1). BMEM byte k goes to word k/B, lane k%B.
- IMEM COMMIT:
  - If tsel >= NUM_THREADS or thread_enabled[tsel]==1: no write, NAK.
  - Otherwise imem_wr_valid[tsel]=1 for exactly that cycle, ACK.
- BMEM COMMIT: bmem_wr_valid=1 for one cycle, ACK; tsel is ignored.
- UPDATE COMMIT:
  - thread_start <= start_mask[NUM_THREADS-1:0] for one cycle;
  - thread_enabled <= enable_mask[NUM_THREADS-1:0];
  - mask bits at or above NUM_THREADS are ignored; ACK.
- PING: ACK.
- Strobe latency: one cycle after the last payload byte handshake (two cycles with CHECK).
- tx_data is stable while tx_valid=1.
- wr_addr, imem_wr_data and bmem_wr_data hold their values until the next command overwrites them.
- Reset mid-command aborts immediately: no strobe, no response.

Optional Feature:
- Macro LOADER_CHECKSUM_EN.
- Defined:
  - every command carries one trailing byte equal to the XOR of header and all payload bytes (state CHECK);
  - on mismatch, COMMIT performs no action and the response is NAK;
  - a PING header goes IDLE -> CHECK.
- Undefined: no trailing byte, no CHECK state, and the XOR logic is absent.

Decomposition:
- Package loader_pkg holds:
  - opcode localparams OP_PING/OP_IMEM/OP_BMEM/OP_UPDATE;
  - the state enum;
  - the ACK/NAK defaults.
- One sub-module, loader_word_assembler: shift-in of a byte stream into a BITWIDTH word with byte counter and done flag, reused for ADDR and DATA words.

Test Plan:
- PING header 8'h00 with tx_ready=1 -> tx_data=8'h06 and tx_valid for 1 cycle; no strobes.
- IMEM, BITWIDTH=32: header 8'h41 (tsel=1), addr bytes 10 00 00 00, data EF BE AD DE ->
  - wr_addr=32'h10, imem_wr_data=32'hDEADBEEF;
  - imem_wr_valid=2'b10 for exactly 1 cycle;
  - ACK.
- UPDATE 8'hC0, start 8'h01, enable 8'h03 -> thread_start=2'b01 for 1 cycle, thread_enabled=2'b11, ACK. A following IMEM write to tsel=0 -> NAK, imem_wr_valid stays 0.
- BMEM, BLOCK_WORDS=4: header 8'h80, addr 00000020, words 1,2,3,4 -> bmem_wr_data={4,3,2,1}, bmem_wr_valid 1 cycle, ACK. Hold tx_ready=0 for 10 cycles: rx_ready stays 0 and tx_data stays 8'h06 throughout.
- IMEM header 8'h47 (tsel=7 >= NUM_THREADS) -> full payload consumed, NAK, no write. Assert reset mid-BMEM payload -> all outputs return to reset values and the next PING gets ACK.
- With LOADER_CHECKSUM_EN: PING 8'h00 followed by checksum 8'h00 -> ACK. PING followed by 8'hFF -> NAK.
